// File: rtl/msrv32_dec_pkg.sv
// Shared decode definitions for the msrv32 decode stage: opcode and funct
// constants, immediate/writeback encodings, SYSTEM words, and the decoded bundle.
package msrv32_dec_pkg;

    // opcode[6:2]
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_PRIV = 3'b000;
    localparam logic [2:0] F3_BAD  = 3'b100;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
    localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

    typedef enum logic [2:0] {
        IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_CSR
    } imm_type_e;

    typedef enum logic [2:0] {
        WB_ALU, WB_LOAD, WB_CSR, WB_PC4, WB_IADDER, WB_IMM, WB_MULDIV
    } wb_sel_e;

    typedef struct packed {
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
        logic [4:0] alu_opcode;
        logic       alu_src;
        logic       iadder_src;
        logic       mem_wr_req;
        logic       rf_wr_en;
        logic       csr_wr_en;
        logic [1:0] load_size;
        logic       load_unsigned;
        wb_sel_e    wb_mux_sel;
        imm_type_e  imm_type;
        logic [2:0] csr_op;
        logic       is_ecall;
        logic       is_ebreak;
        logic       is_mret;
        logic       is_wfi;
        logic       illegal;
        logic       is_load;
        logic       is_store;
    } dec_bundle_t;

    // Word accesses need addr 00, halfwords need addr[0]=0.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr);
        return (size == 2'b10 && addr != 2'b00) ||
               (size == 2'b01 && addr[0]);
    endfunction

endpackage

// File: rtl/msrv32_dec_core.sv
// Combinational RV32I(+M, +Zicsr) decoder: instr -> dec_bundle_t.
// Ports: instr (32-bit word in), bundle (decoded control out).
module msrv32_dec_core
    import msrv32_dec_pkg::*;
#(
    parameter int RV32M_EN = 0,
    parameter int ZICSR_EN = 1
) (
    input  logic [31:0] instr,
    output dec_bundle_t bundle
);

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       enc_ok;
    logic is_op, is_opi, is_ld, is_st, is_br;
    logic is_jalr, is_jal, is_lui, is_auipc, is_fence, is_sys;

    assign opc    = instr[6:2];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign enc_ok = (instr[1:0] == 2'b11);

    assign is_op    = enc_ok && opc == OPC_OP;
    assign is_opi   = enc_ok && opc == OPC_OP_IMM;
    assign is_ld    = enc_ok && opc == OPC_LOAD;
    assign is_st    = enc_ok && opc == OPC_STORE;
    assign is_br    = enc_ok && opc == OPC_BRANCH;
    assign is_jalr  = enc_ok && opc == OPC_JALR;
    assign is_jal   = enc_ok && opc == OPC_JAL;
    assign is_lui   = enc_ok && opc == OPC_LUI;
    assign is_auipc = enc_ok && opc == OPC_AUIPC;
    assign is_fence = enc_ok && opc == OPC_MISC_MEM;
    assign is_sys   = enc_ok && opc == OPC_SYSTEM;

    logic ill, rf_wr, mem_wr, csr_wr, muldiv, ld, st;

    always_comb begin
        bundle            = '0;
        bundle.rs1_addr   = instr[19:15];
        bundle.rs2_addr   = instr[24:20];
        bundle.rd_addr    = instr[11:7];
        bundle.imm_type   = IMM_R;
        bundle.wb_mux_sel = WB_ALU;
        ill    = 1'b0;
        rf_wr  = 1'b0;
        mem_wr = 1'b0;
        csr_wr = 1'b0;
        muldiv = 1'b0;
        ld     = 1'b0;
        st     = 1'b0;
        unique case (1'b1)
            is_op: begin
                bundle.alu_src = 1'b1;
                rf_wr = 1'b1;
                if (f7 == F7_MULDIV && RV32M_EN != 0) begin
                    muldiv = 1'b1;
                    bundle.wb_mux_sel = WB_MULDIV;
                end else if (!(f7 == F7_BASE ||
                               (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)))) begin
                    ill = 1'b1;
                end
                bundle.alu_opcode = {muldiv, instr[30] & ~muldiv, f3};
            end
            is_opi: begin
                rf_wr = 1'b1;
                bundle.imm_type = IMM_I;
                bundle.alu_opcode = {1'b0, (f3 == F3_SR) & instr[30], f3};
                if (f3 == F3_SLL && f7 != F7_BASE)
                    ill = 1'b1;
                if (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT)
                    ill = 1'b1;
            end
            is_ld: begin
                rf_wr = 1'b1;
                ld = 1'b1;
                bundle.iadder_src = 1'b1;
                bundle.imm_type = IMM_I;
                bundle.wb_mux_sel = WB_LOAD;
                bundle.load_size = f3[1:0];
                bundle.load_unsigned = f3[2];
                if (f3 == 3'b011 || f3[2:1] == 2'b11)
                    ill = 1'b1;
            end
            is_st: begin
                mem_wr = 1'b1;
                st = 1'b1;
                bundle.iadder_src = 1'b1;
                bundle.imm_type = IMM_S;
                bundle.load_size = f3[1:0];
                if (f3 >= 3'b011)
                    ill = 1'b1;
            end
            is_br: begin
                bundle.alu_src = 1'b1;
                bundle.imm_type = IMM_B;
                if (f3[2:1] == 2'b01)
                    ill = 1'b1;
            end
            is_jalr: begin
                rf_wr = 1'b1;
                bundle.iadder_src = 1'b1;
                bundle.imm_type = IMM_I;
                bundle.wb_mux_sel = WB_PC4;
                if (f3 != 3'b000)
                    ill = 1'b1;
            end
            is_jal: begin
                rf_wr = 1'b1;
                bundle.imm_type = IMM_J;
                bundle.wb_mux_sel = WB_PC4;
            end
            is_lui: begin
                rf_wr = 1'b1;
                bundle.imm_type = IMM_U;
                bundle.wb_mux_sel = WB_IMM;
            end
            is_auipc: begin
                rf_wr = 1'b1;
                bundle.imm_type = IMM_U;
                bundle.wb_mux_sel = WB_IADDER;
            end
            is_fence: begin
                if (f3 != 3'b000)
                    ill = 1'b1;
            end
            is_sys: begin
                if (f3 == F3_PRIV) begin
                    bundle.is_ecall  = (instr == INSTR_ECALL);
                    bundle.is_ebreak = (instr == INSTR_EBREAK);
                    bundle.is_mret   = (instr == INSTR_MRET);
                    bundle.is_wfi    = (instr == INSTR_WFI);
                    ill = ~(bundle.is_ecall | bundle.is_ebreak |
                            bundle.is_mret | bundle.is_wfi);
                end else if (f3 == F3_BAD) begin
                    ill = 1'b1;
                end else begin
                    rf_wr  = 1'b1;
                    csr_wr = 1'b1;
                    bundle.imm_type = IMM_CSR;
                    bundle.wb_mux_sel = WB_CSR;
                    bundle.csr_op = f3;
                    if (ZICSR_EN == 0)
                        ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        // Illegal words travel on but must not change architectural state.
        bundle.illegal    = ill;
        bundle.rf_wr_en   = rf_wr & ~ill;
        bundle.mem_wr_req = mem_wr & ~ill;
        bundle.csr_wr_en  = csr_wr & ~ill;
        bundle.is_load    = ld & ~ill;
        bundle.is_store   = st & ~ill;
    end

endmodule

// File: rtl/msrv32_dec_stage.sv
// Registered decode stage: decoder + 2-entry skid buffer + misalignment check.
// Ports: clk/rst_n, trap flush, upstream instr/pc handshake, downstream bundle handshake.
module msrv32_dec_stage
    import msrv32_dec_pkg::*;
#(
    parameter int RV32M_EN = 0,
    parameter int ZICSR_EN = 1,
    parameter int PC_WIDTH = 32
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_n_in,
    input  logic                trap_taken_in,
    input  logic                in_valid_in,
    output logic                in_ready_out,
    input  logic [31:0]         instr_in,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic                out_valid_out,
    input  logic                out_ready_in,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [4:0]          rs1_addr_out,
    output logic [4:0]          rs2_addr_out,
    output logic [4:0]          rd_addr_out,
    output logic [4:0]          alu_opcode_out,
    output logic                alu_src_out,
    output logic                iadder_src_out,
    output logic                mem_wr_req_out,
    output logic                rf_wr_en_out,
    output logic                csr_wr_en_out,
    output logic [1:0]          load_size_out,
    output logic                load_unsigned_out,
    output logic [2:0]          wb_mux_sel_out,
    output logic [2:0]          imm_type_out,
    output logic [2:0]          csr_op_out,
    output logic                is_ecall_out,
    output logic                is_ebreak_out,
    output logic                is_mret_out,
    output logic                is_wfi_out,
    output logic                illegal_instr_out,
    input  logic [1:0]          iadder_1_to_0_in,
    output logic                misaligned_load_out,
    output logic                misaligned_store_out
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} skid_state_e;

    skid_state_e         state_q;
    dec_bundle_t         dec, out_q, skid_q;
    logic [PC_WIDTH-1:0] out_pc_q, skid_pc_q;
    logic                out_valid_q, in_ready_q;
    logic                accept, mal;

    msrv32_dec_core #(
        .RV32M_EN (RV32M_EN),
        .ZICSR_EN (ZICSR_EN)
    ) u_core (
        .instr  (instr_in),
        .bundle (dec)
    );

    assign accept = in_valid_in & in_ready_q;

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_q       <= '0;
            skid_q      <= '0;
            out_pc_q    <= '0;
            skid_pc_q   <= '0;
        end else if (trap_taken_in) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        out_q       <= dec;
                        out_pc_q    <= pc_in;
                        out_valid_q <= 1'b1;
                        state_q     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && out_ready_in) begin
                        out_q    <= dec;
                        out_pc_q <= pc_in;
                    end else if (accept) begin
                        // Output is stalled: park the new entry in the skid slot.
                        skid_q     <= dec;
                        skid_pc_q  <= pc_in;
                        in_ready_q <= 1'b0;
                        state_q    <= S_FULL;
                    end else if (out_ready_in) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_ready_in) begin
                        out_q      <= skid_q;
                        out_pc_q   <= skid_pc_q;
                        in_ready_q <= 1'b1;
                        state_q    <= S_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_EMPTY;
                end
            endcase
        end
    end

    assign in_ready_out      = in_ready_q;
    assign out_valid_out     = out_valid_q;
    assign pc_out            = out_pc_q;
    assign rs1_addr_out      = out_q.rs1_addr;
    assign rs2_addr_out      = out_q.rs2_addr;
    assign rd_addr_out       = out_q.rd_addr;
    assign alu_opcode_out    = out_q.alu_opcode;
    assign alu_src_out       = out_q.alu_src;
    assign iadder_src_out    = out_q.iadder_src;
    assign mem_wr_req_out    = out_q.mem_wr_req;
    assign rf_wr_en_out      = out_q.rf_wr_en;
    assign csr_wr_en_out     = out_q.csr_wr_en;
    assign load_size_out     = out_q.load_size;
    assign load_unsigned_out = out_q.load_unsigned;
    assign wb_mux_sel_out    = out_q.wb_mux_sel;
    assign imm_type_out      = out_q.imm_type;
    assign csr_op_out        = out_q.csr_op;
    assign is_ecall_out      = out_q.is_ecall;
    assign is_ebreak_out     = out_q.is_ebreak;
    assign is_mret_out       = out_q.is_mret;
    assign is_wfi_out        = out_q.is_wfi;
    assign illegal_instr_out = out_q.illegal;

    // Address LSBs arrive late from execute, so this stays combinational.
    assign mal = is_misaligned(out_q.load_size, iadder_1_to_0_in);
    assign misaligned_load_out  = out_valid_q & out_q.is_load & mal;
    assign misaligned_store_out = out_valid_q & out_q.is_store & mal;

endmodule

// File: tb/tb_msrv32_dec_stage.sv
// Self-checking bench for msrv32_dec_stage (RV32M off and on instances).
// Ports: none; drives both DUTs with shared stimulus and a scoreboard queue.
module tb_msrv32_dec_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  iaddr;
        logic [4:0]  rd, rs1, rs2, alu;
        logic [2:0]  wb, imm;
        logic        rfw, memw, csrw, ill, ecall, mld, mst;
        logic [4:0]  alu_m;
        logic [2:0]  wb_m;
        logic        ill_m, rfw_m;
    } vec_t;

    logic clk, rst_n, trap, in_valid, out_ready;
    logic [31:0] instr, pc;
    logic [1:0]  iaddr;

    logic in_ready, out_valid, alu_src, iadder_src, mem_wr, rf_wr, csr_wr;
    logic load_uns, ecall, ebreak, mret, wfi, ill, mal_ld, mal_st;
    logic [31:0] pc_o;
    logic [4:0]  rs1, rs2, rd, alu;
    logic [1:0]  load_size;
    logic [2:0]  wb, imm, csr_op;

    logic m_in_ready, m_out_valid, m_alu_src, m_iadder_src, m_mem_wr, m_rf_wr;
    logic m_csr_wr, m_load_uns, m_ecall, m_ebreak, m_mret, m_wfi, m_ill;
    logic m_mal_ld, m_mal_st;
    logic [31:0] m_pc;
    logic [4:0]  m_rs1, m_rs2, m_rd, m_alu;
    logic [1:0]  m_load_size;
    logic [2:0]  m_wb, m_imm, m_csr_op;

    msrv32_dec_stage #(.RV32M_EN(0)) dut (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
        .trap_taken_in(trap), .in_valid_in(in_valid), .in_ready_out(in_ready),
        .instr_in(instr), .pc_in(pc), .out_valid_out(out_valid),
        .out_ready_in(out_ready), .pc_out(pc_o), .rs1_addr_out(rs1),
        .rs2_addr_out(rs2), .rd_addr_out(rd), .alu_opcode_out(alu),
        .alu_src_out(alu_src), .iadder_src_out(iadder_src),
        .mem_wr_req_out(mem_wr), .rf_wr_en_out(rf_wr), .csr_wr_en_out(csr_wr),
        .load_size_out(load_size), .load_unsigned_out(load_uns),
        .wb_mux_sel_out(wb), .imm_type_out(imm), .csr_op_out(csr_op),
        .is_ecall_out(ecall), .is_ebreak_out(ebreak), .is_mret_out(mret),
        .is_wfi_out(wfi), .illegal_instr_out(ill), .iadder_1_to_0_in(iaddr),
        .misaligned_load_out(mal_ld), .misaligned_store_out(mal_st)
    );

    msrv32_dec_stage #(.RV32M_EN(1)) dut_m (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
        .trap_taken_in(trap), .in_valid_in(in_valid), .in_ready_out(m_in_ready),
        .instr_in(instr), .pc_in(pc), .out_valid_out(m_out_valid),
        .out_ready_in(out_ready), .pc_out(m_pc), .rs1_addr_out(m_rs1),
        .rs2_addr_out(m_rs2), .rd_addr_out(m_rd), .alu_opcode_out(m_alu),
        .alu_src_out(m_alu_src), .iadder_src_out(m_iadder_src),
        .mem_wr_req_out(m_mem_wr), .rf_wr_en_out(m_rf_wr),
        .csr_wr_en_out(m_csr_wr), .load_size_out(m_load_size),
        .load_unsigned_out(m_load_uns), .wb_mux_sel_out(m_wb),
        .imm_type_out(m_imm), .csr_op_out(m_csr_op), .is_ecall_out(m_ecall),
        .is_ebreak_out(m_ebreak), .is_mret_out(m_mret), .is_wfi_out(m_wfi),
        .illegal_instr_out(m_ill), .iadder_1_to_0_in(iaddr),
        .misaligned_load_out(m_mal_ld), .misaligned_store_out(m_mal_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] cur_instr = '0;
    vec_t sbq[$];
    vec_t tbl[18];
    localparam int N = 18;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (instr %08h): got %0h expected %0h",
                     name, cur_instr, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [1:0] ia,
        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
        input logic [4:0] a, input logic [2:0] w, input logic [2:0] im,
        input logic rw, input logic mw, input logic cw, input logic il,
        input logic ec, input logic ml, input logic ms);
        vec_t v;
        v.instr = i; v.pc = '0; v.iaddr = ia;
        v.rd = d; v.rs1 = s1; v.rs2 = s2; v.alu = a; v.wb = w; v.imm = im;
        v.rfw = rw; v.memw = mw; v.csrw = cw; v.ill = il; v.ecall = ec;
        v.mld = ml; v.mst = ms;
        v.alu_m = a; v.wb_m = w; v.ill_m = il; v.rfw_m = rw;
        return v;
    endfunction

    task automatic compare(input vec_t e);
        cur_instr = e.instr;
        chk("pc", pc_o, e.pc);
        chk("rd", 32'(rd), 32'(e.rd));
        chk("rs1", 32'(rs1), 32'(e.rs1));
        chk("rs2", 32'(rs2), 32'(e.rs2));
        chk("alu_opcode", 32'(alu), 32'(e.alu));
        chk("wb_mux_sel", 32'(wb), 32'(e.wb));
        chk("imm_type", 32'(imm), 32'(e.imm));
        chk("rf_wr_en", 32'(rf_wr), 32'(e.rfw));
        chk("mem_wr_req", 32'(mem_wr), 32'(e.memw));
        chk("csr_wr_en", 32'(csr_wr), 32'(e.csrw));
        chk("illegal", 32'(ill), 32'(e.ill));
        chk("is_ecall", 32'(ecall), 32'(e.ecall));
        chk("misaligned_load", 32'(mal_ld), 32'(e.mld));
        chk("misaligned_store", 32'(mal_st), 32'(e.mst));
        chk("m_pc", m_pc, e.pc);
        chk("m_alu_opcode", 32'(m_alu), 32'(e.alu_m));
        chk("m_wb_mux_sel", 32'(m_wb), 32'(e.wb_m));
        chk("m_illegal", 32'(m_ill), 32'(e.ill_m));
        chk("m_rf_wr_en", 32'(m_rf_wr), 32'(e.rfw_m));
    endtask

    // One cycle: drive at the falling edge, compare/pop outputs, push accepted input.
    task automatic step(input logic v, input vec_t e, input logic ord,
                        input logic tr, output logic acc);
        in_valid = v;
        instr = e.instr;
        pc = e.pc;
        out_ready = ord;
        trap = tr;
        iaddr = (sbq.size() > 0) ? sbq[0].iaddr : 2'b00;
        #1;
        if (out_valid && out_ready && !tr) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got pc %0h expected no output", pc_o);
            end else begin
                compare(sbq.pop_front());
            end
        end
        acc = v && in_ready && !tr;
        if (acc)
            sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        logic a;
        for (int k = 0; k < 20 && sbq.size() > 0; k++)
            step(1'b0, tbl[0], 1'b1, 1'b0, a);
        cur_instr = '0;
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        int i, cyc;
        rst_n = 1'b0; trap = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0; iaddr = '0;

        tbl[0]  = mk(32'h002081B3, 2'b00, 3, 1, 2, 5'b00000, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(32'h402081B3, 2'b00, 3, 1, 2, 5'b01000, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(32'h022081B3, 2'b00, 3, 1, 2, 5'b00000, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0);
        tbl[2].alu_m = 5'b10000; tbl[2].wb_m = 3'b110;
        tbl[2].ill_m = 1'b0;     tbl[2].rfw_m = 1'b1;
        tbl[3]  = mk(32'h0020A223, 2'b00, 4, 1, 2, 5'b00000, 3'b000, 3'b010, 0, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(32'h0040A183, 2'b10, 3, 1, 4, 5'b00000, 3'b001, 3'b001, 1, 0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(32'h00409183, 2'b10, 3, 1, 4, 5'b00000, 3'b001, 3'b001, 1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(32'h00209223, 2'b01, 4, 1, 2, 5'b00000, 3'b000, 3'b010, 0, 1, 0, 0, 0, 0, 1);
        tbl[7]  = mk(32'h00000073, 2'b00, 0, 0, 0, 5'b00000, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 0);
        tbl[8]  = mk(32'h000002B7, 2'b00, 5, 0, 0, 5'b00000, 3'b101, 3'b100, 1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(32'h000000EF, 2'b00, 1, 0, 0, 5'b00000, 3'b011, 3'b101, 1, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(32'h4020D193, 2'b00, 3, 1, 2, 5'b01101, 3'b000, 3'b001, 1, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(32'h40209193, 2'b00, 3, 1, 2, 5'b00001, 3'b000, 3'b001, 0, 0, 0, 1, 0, 0, 0);
        tbl[12] = mk(32'h300091F3, 2'b00, 3, 1, 0, 5'b00000, 3'b010, 3'b110, 1, 0, 1, 0, 0, 0, 0);
        tbl[13] = mk(32'h00000000, 2'b00, 0, 0, 0, 5'b00000, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0);
        tbl[14] = mk(32'h00208063, 2'b00, 0, 1, 2, 5'b00000, 3'b000, 3'b011, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(32'h00200073, 2'b00, 0, 0, 2, 5'b00000, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0);
        tbl[16] = mk(32'h0000000F, 2'b00, 0, 0, 0, 5'b00000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(32'h0040B183, 2'b10, 3, 1, 4, 5'b00000, 3'b001, 3'b001, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < N; k++)
            tbl[k].pc = 32'h100 + 32'(k) * 4;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_alu_opcode", 32'(alu), 0);
        chk("rst_illegal", 32'(ill), 0);
        chk("rst_pc", pc_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Streaming pass with out_ready held high.
        step(1'b1, tbl[0], 1'b1, 1'b0, acc);
        cur_instr = tbl[0].instr;
        chk("latency_out_valid", 32'(out_valid), 1);
        for (int k = 1; k < N; k++)
            step(1'b1, tbl[k], 1'b1, 1'b0, acc);
        drain();

        // Random downstream stalls; resend until accepted.
        i = 0;
        cyc = 0;
        while (i < N && cyc < 400) begin
            step(1'b1, tbl[i], 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc)
                i++;
            cyc++;
        end
        cur_instr = '0;
        chk("random_all_accepted", 32'(i), 32'(N));
        drain();

        // Backpressure: SW then LW with output stalled.
        step(1'b1, tbl[3], 1'b0, 1'b0, acc);
        step(1'b1, tbl[4], 1'b0, 1'b0, acc);
        chk("bp_in_ready_full", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        step(1'b1, tbl[0], 1'b0, 1'b0, acc);
        chk("bp_refused", 32'(acc), 0);
        chk("bp_hold_pc", pc_o, tbl[3].pc);
        drain();

        // Flush from FULL with a concurrent offer.
        step(1'b1, tbl[0], 1'b0, 1'b0, acc);
        step(1'b1, tbl[1], 1'b0, 1'b0, acc);
        chk("fl_in_ready_full", 32'(in_ready), 0);
        step(1'b1, tbl[8], 1'b0, 1'b1, acc);
        chk("fl_full_out_valid", 32'(out_valid), 0);
        chk("fl_full_in_ready", 32'(in_ready), 1);
        sbq.delete();
        // Flush from ONE while the upstream handshake would succeed.
        step(1'b1, tbl[5], 1'b0, 1'b0, acc);
        step(1'b1, tbl[9], 1'b1, 1'b1, acc);
        chk("fl_one_out_valid", 32'(out_valid), 0);
        sbq.delete();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, tbl[9], 1'b1, 1'b0, acc);
            chk("fl_idle_out_valid", 32'(out_valid), 0);
        end
        step(1'b1, tbl[12], 1'b1, 1'b0, acc);
        drain();

        // Asynchronous reset mid-operation.
        step(1'b1, tbl[10], 1'b0, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_rf_wr_en", 32'(rf_wr), 0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
